// File: rtl/tmr_vote_monitor_pkg.sv
// Shared types for the TMR vote monitor: health states, copy identifiers
// and the helper that names the copy blamed for a single-copy disagreement.
package tmr_mon_pkg;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        SUSPECT  = 2'd1,
        DEGRADED = 2'd2,
        FAILED   = 2'd3
    } health_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        A    = 2'd1,
        B    = 2'd2,
        C    = 2'd3
    } copy_id_t;

    // Width of the consecutive same-copy error streak counter.
    localparam int STREAK_W = 4;

    // Identify the single disagreeing copy; NONE when no bit (or more than
    // one bit) is set, so callers only use it when exactly one is set.
    function automatic copy_id_t blame(input logic m_a, input logic m_b, input logic m_c);
        copy_id_t id;
        id = NONE;
        if (m_a && !m_b && !m_c) id = A;
        else if (!m_a && m_b && !m_c) id = B;
        else if (!m_a && !m_b && m_c) id = C;
        return id;
    endfunction

endpackage

// File: rtl/tmr_vote_monitor_majority3.sv
// Purely combinational bitwise 2-of-3 voter with per-copy disagreement flags.
module tmr_majority3 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    input  logic [WIDTH-1:0] d_c,
    output logic [WIDTH-1:0] vote,
    output logic             m_a,
    output logic             m_b,
    output logic             m_c
);

    // Each output bit takes the value held by at least two of the copies.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign vote[gi] = (d_a[gi] & d_b[gi]) | (d_a[gi] & d_c[gi]) | (d_b[gi] & d_c[gi]);
        end
    endgenerate

    assign m_a = (d_a != vote);
    assign m_b = (d_b != vote);
    assign m_c = (d_c != vote);

endmodule

// File: rtl/tmr_vote_monitor.sv
// TMR vote monitor: registers the majority-voted word, pulses single/multi
// disagreement flags, counts errored words and tracks copy health.
module tmr_vote_monitor
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter int THRESH = 3
) (
    input  logic             c,
    input  logic             rst,
    input  logic [WIDTH-1:0] dA,
    input  logic [WIDTH-1:0] dB,
    input  logic [WIDTH-1:0] dC,
    input  logic             valid_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] q,
    output logic             err_single,
    output logic             err_multi,
    output logic [1:0]       bad_copy,
    output logic [1:0]       health,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [STREAK_W-1:0] THRESH_V = STREAK_W'(THRESH);

    logic [WIDTH-1:0]    vote;
    logic                m_a, m_b, m_c;
    logic                single_err, multi_err;
    copy_id_t            blamed;
    logic [STREAK_W-1:0] streak_inc;

    health_t             health_q, health_d;
    copy_id_t            bad_q, bad_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                es_q, es_d;
    logic                em_q, em_d;

    tmr_majority3 #(.WIDTH(WIDTH)) u_vote (
        .d_a  (dA),
        .d_b  (dB),
        .d_c  (dC),
        .vote (vote),
        .m_a  (m_a),
        .m_b  (m_b),
        .m_c  (m_c)
    );

    assign multi_err  = (m_a & m_b) | (m_a & m_c) | (m_b & m_c);
    assign single_err = (m_a | m_b | m_c) & ~multi_err;
    assign blamed     = blame(m_a, m_b, m_c);
    assign streak_inc = streak_q + STREAK_W'(1);

    // State register: FSM, streak, blame, counter, data and flag flops.
    always_ff @(posedge c) begin
        if (rst) begin
            health_q <= OK;
            bad_q    <= NONE;
            streak_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            es_q     <= 1'b0;
            em_q     <= 1'b0;
        end else begin
            health_q <= health_d;
            bad_q    <= bad_d;
            streak_q <= streak_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            es_q     <= es_d;
            em_q     <= em_d;
        end
    end

    // Next health state, streak and blamed copy; clear wins over evaluation.
    always_comb begin
        health_d = health_q;
        bad_d    = bad_q;
        streak_d = streak_q;
        if (clr_i) begin
            health_d = OK;
            bad_d    = NONE;
            streak_d = '0;
        end else if (valid_i) begin
            if (multi_err) begin
                health_d = FAILED;
            end else begin
                case (health_q)
                    OK: begin
                        if (single_err) begin
                            bad_d    = blamed;
                            streak_d = STREAK_W'(1);
                            health_d = (THRESH_V <= STREAK_W'(1)) ? DEGRADED : SUSPECT;
                        end
                    end
                    SUSPECT: begin
                        if (single_err) begin
                            if (blamed == bad_q) begin
                                streak_d = streak_inc;
                                if (streak_inc >= THRESH_V) health_d = DEGRADED;
                            end else begin
                                bad_d    = blamed;
                                streak_d = STREAK_W'(1);
                            end
                        end else begin
                            health_d = OK;
                            streak_d = '0;
                        end
                    end
                    default: begin
                        // DEGRADED and FAILED are sticky until clear or reset.
                        health_d = health_q;
                    end
                endcase
            end
        end
    end

    // Data path, flag pulses and saturating errored-word counter.
    always_comb begin
        data_d = valid_i ? vote : data_q;
        es_d   = valid_i & single_err;
        em_d   = valid_i & multi_err;
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (valid_i && (single_err || multi_err) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FSM outputs are the registered state directly.
    always_comb begin
        health     = health_q;
        bad_copy   = bad_q;
        q          = data_q;
        err_single = es_q;
        err_multi  = em_q;
        err_cnt    = cnt_q;
    end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: vector table for the default build,
// plus hand sequences for counter saturation (CNT_W=4) and THRESH=1.
`timescale 1ns/1ps
module tb_tmr_vote_monitor;

    logic       c = 1'b0;
    logic       rst = 1'b1;
    logic       clr_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] dA = 8'h00, dB = 8'h00, dC = 8'h00;

    logic [7:0]  q, q_s, q_t;
    logic        es, em, es_s, em_s, es_t, em_t;
    logic [1:0]  bad, bad_s, bad_t, h, h_s, h_t;
    logic [15:0] cnt, cnt_t;
    logic [3:0]  cnt_s;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 c = ~c;

    tmr_vote_monitor #(.WIDTH(8), .CNT_W(16), .THRESH(3)) dut (
        .c(c), .rst(rst), .dA(dA), .dB(dB), .dC(dC), .valid_i(valid_i), .clr_i(clr_i),
        .q(q), .err_single(es), .err_multi(em), .bad_copy(bad), .health(h), .err_cnt(cnt)
    );

    tmr_vote_monitor #(.WIDTH(8), .CNT_W(4), .THRESH(3)) dut_s (
        .c(c), .rst(rst), .dA(dA), .dB(dB), .dC(dC), .valid_i(valid_i), .clr_i(clr_i),
        .q(q_s), .err_single(es_s), .err_multi(em_s), .bad_copy(bad_s), .health(h_s), .err_cnt(cnt_s)
    );

    tmr_vote_monitor #(.WIDTH(8), .CNT_W(16), .THRESH(1)) dut_t (
        .c(c), .rst(rst), .dA(dA), .dB(dB), .dC(dC), .valid_i(valid_i), .clr_i(clr_i),
        .q(q_t), .err_single(es_t), .err_multi(em_t), .bad_copy(bad_t), .health(h_t), .err_cnt(cnt_t)
    );

    typedef struct {
        logic        rst, clr, valid;
        logic [7:0]  a, b, cc;
        logic [7:0]  q;
        logic        es, em;
        logic [1:0]  bad, h;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic cl, input logic v,
                                input logic [7:0] a, input logic [7:0] b, input logic [7:0] cc,
                                input logic [7:0] eq, input logic ees, input logic eem,
                                input logic [1:0] ebad, input logic [1:0] eh, input logic [15:0] ecnt);
        vec_t t;
        t.rst = r; t.clr = cl; t.valid = v; t.a = a; t.b = b; t.cc = cc;
        t.q = eq; t.es = ees; t.em = eem; t.bad = ebad; t.h = eh; t.cnt = ecnt;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cl, input logic v,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] cc);
        rst = r; clr_i = cl; valid_i = v; dA = a; dB = b; dC = cc;
        @(posedge c);
        #1;
    endtask

    initial begin
        int n;
        // rst clr v   A      B      C      q      es em  bad   h     cnt
        vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 2'd0, 16'd0);
        vecs[1]  = mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 2'd0, 16'd0);
        vecs[2]  = mk(0, 0, 1, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 0, 0, 2'd0, 2'd0, 16'd0);
        vecs[3]  = mk(0, 0, 1, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 1, 0, 2'd2, 2'd1, 16'd1);
        vecs[4]  = mk(0, 0, 1, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 1, 0, 2'd2, 2'd1, 16'd2);
        vecs[5]  = mk(0, 0, 1, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 1, 0, 2'd2, 2'd2, 16'd3);
        vecs[6]  = mk(0, 0, 0, 8'h00, 8'h5B, 8'h00, 8'h5A, 0, 0, 2'd2, 2'd2, 16'd3);
        vecs[7]  = mk(0, 1, 1, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd0, 2'd0, 16'd0);
        vecs[8]  = mk(0, 0, 1, 8'h3D, 8'h3C, 8'h3C, 8'h3C, 1, 0, 2'd1, 2'd1, 16'd1);
        vecs[9]  = mk(0, 0, 1, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd1, 2'd0, 16'd1);
        vecs[10] = mk(0, 0, 1, 8'h3D, 8'h3C, 8'h3C, 8'h3C, 1, 0, 2'd1, 2'd1, 16'd2);
        vecs[11] = mk(0, 0, 1, 8'h3C, 8'h3C, 8'h3E, 8'h3C, 1, 0, 2'd3, 2'd1, 16'd3);
        vecs[12] = mk(0, 0, 1, 8'h3C, 8'h3C, 8'h3E, 8'h3C, 1, 0, 2'd3, 2'd1, 16'd4);
        vecs[13] = mk(0, 0, 0, 8'hFF, 8'h00, 8'h3E, 8'h3C, 0, 0, 2'd3, 2'd1, 16'd4);
        vecs[14] = mk(0, 0, 1, 8'h3C, 8'h3C, 8'h3E, 8'h3C, 1, 0, 2'd3, 2'd2, 16'd5);
        vecs[15] = mk(0, 0, 1, 8'h3D, 8'h3C, 8'h3C, 8'h3C, 1, 0, 2'd3, 2'd2, 16'd6);
        vecs[16] = mk(0, 0, 1, 8'h01, 8'h02, 8'h04, 8'h00, 0, 1, 2'd3, 2'd3, 16'd7);
        vecs[17] = mk(0, 0, 1, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 0, 0, 2'd3, 2'd3, 16'd7);
        vecs[18] = mk(0, 0, 1, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 1, 0, 2'd3, 2'd3, 16'd8);
        vecs[19] = mk(0, 1, 1, 8'h01, 8'h02, 8'h04, 8'h00, 0, 1, 2'd0, 2'd0, 16'd0);
        vecs[20] = mk(1, 1, 1, 8'h01, 8'h02, 8'hF4, 8'h00, 0, 0, 2'd0, 2'd0, 16'd0);
        vecs[21] = mk(0, 0, 1, 8'h81, 8'h80, 8'h80, 8'h80, 1, 0, 2'd1, 2'd1, 16'd1);
        vecs[22] = mk(0, 0, 1, 8'h81, 8'h80, 8'h80, 8'h80, 1, 0, 2'd1, 2'd1, 16'd2);
        vecs[23] = mk(1, 0, 1, 8'h81, 8'h80, 8'h80, 8'h00, 0, 0, 2'd0, 2'd0, 16'd0);
        vecs[24] = mk(0, 0, 1, 8'h81, 8'h80, 8'h80, 8'h80, 1, 0, 2'd1, 2'd1, 16'd1);
        vecs[25] = mk(0, 0, 1, 8'h81, 8'h80, 8'h80, 8'h80, 1, 0, 2'd1, 2'd1, 16'd2);
        vecs[26] = mk(0, 0, 1, 8'h81, 8'h80, 8'h80, 8'h80, 1, 0, 2'd1, 2'd2, 16'd3);
        vecs[27] = mk(0, 0, 1, 8'h01, 8'h02, 8'h00, 8'h00, 0, 1, 2'd1, 2'd3, 16'd4);
        vecs[28] = mk(0, 0, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, 2'd1, 2'd3, 16'd4);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].cc);
            $display("[TB] vec %0d: q=%02h es=%0b em=%0b bad=%0d health=%0d cnt=%0d",
                     i, q, es, em, bad, h, cnt);
            check("q",          i, {8'h00, q},      {8'h00, vecs[i].q});
            check("err_single", i, {15'd0, es},     {15'd0, vecs[i].es});
            check("err_multi",  i, {15'd0, em},     {15'd0, vecs[i].em});
            check("bad_copy",   i, {14'd0, bad},    {14'd0, vecs[i].bad});
            check("health",     i, {14'd0, h},      {14'd0, vecs[i].h});
            check("err_cnt",    i, cnt,             vecs[i].cnt);
        end

        // Saturation on the 4-bit counter build, with idle gaps between words.
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
        check("sat_reset", 0, {12'd0, cnt_s}, 16'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 8'h5A, 8'h5B, 8'h5A);
            if (n < 15) n++;
            $display("[TB] sat word %0d: err_cnt=%0d", i, cnt_s);
            check("sat_cnt", i, {12'd0, cnt_s}, 16'(n));
            drive(0, 0, 0, 8'h5A, 8'h5B, 8'h5A);
            $display("[TB] sat gap %0d: err_cnt=%0d", i, cnt_s);
            check("sat_gap", i, {12'd0, cnt_s}, 16'(n));
        end

        // THRESH=1: the first single error from OK degrades immediately.
        drive(1, 0, 0, 8'h00, 8'h00, 8'h00);
        drive(0, 0, 1, 8'h10, 8'h10, 8'h11);
        $display("[TB] thresh1 err: health=%0d bad=%0d cnt=%0d", h_t, bad_t, cnt_t);
        check("t1_health", 0, {14'd0, h_t},   16'd2);
        check("t1_bad",    0, {14'd0, bad_t}, 16'd3);
        check("t1_single", 0, {15'd0, es_t},  16'd1);
        drive(0, 0, 1, 8'h10, 8'h10, 8'h10);
        $display("[TB] thresh1 clean: health=%0d", h_t);
        check("t1_sticky", 1, {14'd0, h_t},   16'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
